// File: rtl/vm_disp_pkg.sv
// rtl/vm_disp_pkg.sv - shared seven-segment display constants and scan helpers
package vm_disp_pkg;

  // Default number of stable samples before a scanned digit is accepted
  localparam int SETTLE_DEFAULT = 4;

  // Active-low glyphs, bit0 = segment a .. bit6 = segment g
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // All segments off
  localparam logic [6:0] BLANK_CODE = 7'h7F;

  typedef enum logic [1:0] {
    DCLS_IDLE,
    DCLS_SELECT,
    DCLS_MULTI
  } digit_class_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLING,
    ST_HELD
  } scan_state_t;

  // No select low = idle, exactly one low = a valid select, more = bus fault
  function automatic digit_class_t classify_digit(input logic [7:0] digit);
    int zeros;
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      if (!digit[i]) zeros = zeros + 1;
    end
    if (zeros == 0) return DCLS_IDLE;
    else if (zeros == 1) return DCLS_SELECT;
    else return DCLS_MULTI;
  endfunction

  // Position of the low bit; only meaningful for a SELECT pattern
  function automatic logic [2:0] digit_index(input logic [7:0] digit);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!digit[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// rtl/seg7_glyph_decode.sv - active-low segment pattern to hex nibble decoder
module seg7_glyph_decode
  import vm_disp_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       blank_o,
  output logic       bad_o
);

  // Anything that is neither a hex glyph nor fully dark is flagged bad
  always_comb begin
    nibble_o = 4'h0;
    blank_o  = 1'b0;
    bad_o    = 1'b0;
    case (seg_i)
      GLYPH_0:    nibble_o = 4'h0;
      GLYPH_1:    nibble_o = 4'h1;
      GLYPH_2:    nibble_o = 4'h2;
      GLYPH_3:    nibble_o = 4'h3;
      GLYPH_4:    nibble_o = 4'h4;
      GLYPH_5:    nibble_o = 4'h5;
      GLYPH_6:    nibble_o = 4'h6;
      GLYPH_7:    nibble_o = 4'h7;
      GLYPH_8:    nibble_o = 4'h8;
      GLYPH_9:    nibble_o = 4'h9;
      GLYPH_A:    nibble_o = 4'hA;
      GLYPH_B:    nibble_o = 4'hB;
      GLYPH_C:    nibble_o = 4'hC;
      GLYPH_D:    nibble_o = 4'hD;
      GLYPH_E:    nibble_o = 4'hE;
      GLYPH_F:    nibble_o = 4'hF;
      BLANK_CODE: blank_o  = 1'b1;
      default:    bad_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_monitor.sv
// rtl/seg_scan_monitor.sv - snoops a multiplexed 8-digit display and recovers its value
module seg_scan_monitor
  import vm_disp_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  DIGIT,
  input  logic [6:0]  SEG,
  output logic [31:0] disp_val,
  output logic [7:0]  disp_blank,
  output logic [7:0]  disp_bad,
  output logic        frame_done,
  output logic [31:0] frame_val,
  output logic        scan_err,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0] SETTLE_W = SETTLE[7:0];

  logic [7:0]   digit_s_q, digit_p_q;
  logic [6:0]   seg_s_q, seg_p_q;
  scan_state_t  state_q, state_d;
  logic [7:0]   count_q, count_d;
  logic [7:0]   seen_q, seen_d;
  logic         capture;
  logic         err_d;
  logic         frame_hit;
  logic         changed;
  digit_class_t cls_s, cls_p;
  logic [2:0]   idx;
  logic [3:0]   dec_nibble;
  logic         dec_blank, dec_bad;
  logic [31:0]  val_d;
  logic [7:0]   blank_d, bad_d;

  seg7_glyph_decode u_decode (
    .seg_i    (seg_s_q),
    .nibble_o (dec_nibble),
    .blank_o  (dec_blank),
    .bad_o    (dec_bad)
  );

  // Input stage plus one-sample history used for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_s_q <= 8'hFF;
      seg_s_q   <= 7'h7F;
      digit_p_q <= 8'hFF;
      seg_p_q   <= 7'h7F;
    end else begin
      digit_s_q <= DIGIT;
      seg_s_q   <= SEG;
      digit_p_q <= digit_s_q;
      seg_p_q   <= seg_s_q;
    end
  end

  assign changed = {digit_s_q, seg_s_q} != {digit_p_q, seg_p_q};
  assign cls_s   = classify_digit(digit_s_q);
  assign cls_p   = classify_digit(digit_p_q);
  assign idx     = digit_index(digit_s_q);

  // Settle tracking: a new pattern restarts the count, a steady one advances it
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    capture = 1'b0;
    err_d   = 1'b0;
    if (changed) begin
      case (cls_s)
        DCLS_IDLE: begin
          state_d = ST_IDLE;
          count_d = 8'd0;
        end
        DCLS_MULTI: begin
          state_d = ST_IDLE;
          count_d = 8'd0;
          err_d   = (cls_p != DCLS_MULTI);
        end
        default: begin
          count_d = 8'd1;
          if (SETTLE_W == 8'd1) begin
            capture = 1'b1;
            state_d = ST_HELD;
          end else begin
            state_d = ST_SETTLING;
          end
        end
      endcase
    end else if (state_q == ST_SETTLING) begin
      count_d = count_q + 8'd1;
      if (count_d == SETTLE_W) begin
        capture = 1'b1;
        state_d = ST_HELD;
      end
    end
  end

  // Digit update and frame completion for the capture decided above
  always_comb begin
    val_d     = disp_val;
    blank_d   = disp_blank;
    bad_d     = disp_bad;
    seen_d    = seen_q;
    frame_hit = 1'b0;
    if (capture) begin
      val_d[{idx, 2'b00} +: 4] = dec_nibble;
      blank_d[idx]             = dec_blank;
      bad_d[idx]               = dec_bad;
      seen_d[idx]              = 1'b1;
      if (seen_d == 8'hFF) begin
        frame_hit = 1'b1;
        seen_d    = 8'h00;
      end
    end
  end

  // Scan FSM with all of its registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= 8'd0;
      seen_q     <= 8'h00;
      disp_val   <= 32'h0;
      disp_blank <= 8'hFF;
      disp_bad   <= 8'h00;
      frame_done <= 1'b0;
      frame_val  <= 32'h0;
      scan_err   <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      seen_q     <= seen_d;
      disp_val   <= val_d;
      disp_blank <= blank_d;
      disp_bad   <= bad_d;
      frame_done <= frame_hit;
      if (frame_hit) frame_val <= val_d;
      scan_err   <= err_d;
      if (err_d && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
